// File: rtl/req_ack_multibeat_sender.sv
// Buffers wide words in a small FIFO and sends each one as BEATS narrow beats over a 2-phase req/ack link.
// Optional ack watchdog: define REQ_ACK_TIMEOUT_EN to build the ack_timeout counter.
module req_ack_multibeat_sender #(
  parameter int DOUT_W      = 32,
  parameter int BEATS       = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int DIN_W      = DOUT_W * BEATS,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DIN_W-1:0]  din,
  input  logic              valid,
  output logic              available,
  output logic [LVL_W-1:0]  level,
  output logic              request,
  input  logic              acknowledge,
  output logic [DOUT_W-1:0] dout,
  output logic              ack_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (BEATS < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("req_ack_multibeat_sender: illegal parameter combination");
  end

  // Handshake: a word enters on valid & available; each request toggle offers one
  // beat on dout, and the matching acknowledge toggle releases the next beat.
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;
  state_t state_q, state_d;

  logic [DIN_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_d;
  logic [LVL_W-1:0]  level_d;
  logic [DOUT_W-1:0] beat_data;
  logic              ack_s1, ack_s2, ack_d, ack_pulse;
  logic              push, pop, send;

  assign push      = valid & available;
  assign ack_pulse = ack_s2 ^ ack_d;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt;
    send       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level != '0) begin
          send       = 1'b1;
          beat_cnt_d = '0;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_pulse) begin
          if (beat_cnt == CNT_W'(BEATS - 1)) begin
            pop        = 1'b1;
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            send       = 1'b1;
            beat_cnt_d = beat_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MSB-first beat selection from the head word.
  always_comb begin
    beat_data = '0;
    beat_data = DOUT_W'(mem[rd_ptr] >> ((BEATS - 1 - int'(beat_cnt_d)) * DOUT_W));
  end

  always_comb begin
    level_d = level;
    case ({push, pop})
      2'b10:   level_d = level + 1'b1;
      2'b01:   level_d = level - 1'b1;
      default: level_d = level;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      beat_cnt  <= '0;
      level     <= '0;
      available <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      request   <= 1'b0;
      dout      <= '0;
      ack_s1    <= 1'b0;
      ack_s2    <= 1'b0;
      ack_d     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_cnt  <= beat_cnt_d;
      level     <= level_d;
      available <= (level_d < LVL_W'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (send) begin
        request <= ~request;
        dout    <= beat_data;
      end
      ack_s1 <= acknowledge;
      ack_s2 <= ack_s1;
      ack_d  <= ack_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

`ifdef REQ_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Saturating wait counter; the flag is sticky and nothing is retransmitted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt      <= '0;
      ack_timeout <= 1'b0;
    end else if (send) begin
      to_cnt <= '0;
    end else if (state_q == WAIT_ACK && to_cnt != TO_W'(TIMEOUT_CYC)) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) ack_timeout <= 1'b1;
    end
  end
`else
  assign ack_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_multibeat_sender.sv
// Directed bench for req_ack_multibeat_sender: a BEATS=2 instance and a BEATS=4 instance share clock and reset.
module tb_req_ack_multibeat_sender;

`ifdef REQ_ACK_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [63:0]  din;
  logic         valid, available, request, acknowledge, ack_timeout;
  logic [2:0]   level;
  logic [31:0]  dout;
  logic [127:0] b_din;
  logic         b_valid, b_available, b_request, b_ack, b_ack_timeout;
  logic [2:0]   b_level;
  logic [31:0]  b_dout;

  int passed = 0;
  int total  = 0;
  logic [63:0] w [5];

  always #5 clk = ~clk;

  req_ack_multibeat_sender #(.DOUT_W(32), .BEATS(2), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rstn(rstn), .din(din), .valid(valid), .available(available), .level(level),
    .request(request), .acknowledge(acknowledge), .dout(dout), .ack_timeout(ack_timeout)
  );

  req_ack_multibeat_sender #(.DOUT_W(32), .BEATS(4), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) u_dut4 (
    .clk(clk), .rstn(rstn), .din(b_din), .valid(b_valid), .available(b_available), .level(b_level),
    .request(b_request), .acknowledge(b_ack), .dout(b_dout), .ack_timeout(b_ack_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges and return on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    w[0] = 64'h11111111_22222222;
    w[1] = 64'h33333333_44444444;
    w[2] = 64'h55555555_66666666;
    w[3] = 64'h77777777_88888888;
    w[4] = 64'h99999999_AAAAAAAA;
    rstn = 1'b0; din = '0; valid = 1'b0; acknowledge = 1'b0;
    b_din = '0; b_valid = 1'b0; b_ack = 1'b0;
    step(3);
    check("rst_request", 64'(request), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_available", 64'(available), 64'd1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_timeout", 64'(ack_timeout), 64'd0);
    check("rst_b_request", 64'(b_request), 64'd0);
    check("rst_b_level", 64'(b_level), 64'd0);
    rstn = 1'b1;
    step(1);

    // single word, two beats
    din = 64'hAAAABBBB_CCCCDDDD; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("one_level_after_push", 64'(level), 64'd1);
    check("one_request_before_send", 64'(request), 64'd0);
    step(1);
    check("one_beat0_request", 64'(request), 64'd1);
    check("one_beat0_dout", 64'(dout), 64'hAAAABBBB);
    acknowledge = 1'b1;
    step(2);
    check("one_request_hold_2nd_edge", 64'(request), 64'd1);
    step(1);
    check("one_beat1_request", 64'(request), 64'd0);
    check("one_beat1_dout", 64'(dout), 64'hCCCCDDDD);
    acknowledge = 1'b0;
    step(2);
    check("one_level_before_pop", 64'(level), 64'd1);
    step(1);
    check("one_level_after_pop", 64'(level), 64'd0);
    check("one_state_idle", 64'(u_dut.state_q), 64'd0);

    // ack toggle while idle and empty
    acknowledge = 1'b1;
    step(5);
    check("idle_ack_request", 64'(request), 64'd0);
    check("idle_ack_dout", 64'(dout), 64'hCCCCDDDD);
    check("idle_ack_level", 64'(level), 64'd0);

    // fill the FIFO with ack held
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = w[i];
      step(1);
      if (i == 3) begin
        check("fill_level_4", 64'(level), 64'd4);
        check("fill_available_0", 64'(available), 64'd0);
      end
    end
    valid = 1'b0;
    check("fill_5th_rejected", 64'(level), 64'd4);
    check("fill_w0_request", 64'(request), 64'd1);
    check("fill_w0_beat0", 64'(dout), 64'h11111111);
    acknowledge = 1'b0;
    step(3);
    check("fill_w0_beat1_req", 64'(request), 64'd0);
    check("fill_w0_beat1", 64'(dout), 64'h22222222);
    check("fill_level_still_4", 64'(level), 64'd4);
    acknowledge = 1'b1;
    step(3);
    check("pop_level_3", 64'(level), 64'd3);
    check("pop_available_1", 64'(available), 64'd1);
    check("pop_request_hold", 64'(request), 64'd0);
    step(1);
    check("w1_beat0_request", 64'(request), 64'd1);
    check("w1_beat0_dout", 64'(dout), 64'h33333333);

    // reset in mid-transfer
    rstn = 1'b0;
    #1;
    check("midrst_request", 64'(request), 64'd0);
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_available", 64'(available), 64'd1);
    @(negedge clk);
    acknowledge = 1'b0;
    rstn = 1'b1;
    step(4);
    acknowledge = 1'b1;
    step(4);
    acknowledge = 1'b0;
    step(4);
    check("postrst_request", 64'(request), 64'd0);
    check("postrst_level", 64'(level), 64'd0);
    check("postrst_dout", 64'(dout), 64'd0);

    // ack watchdog, ack never toggled
    din = w[2]; valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(1);
    check("to_request", 64'(request), 64'd1);
    step(15);
    check("to_not_yet", 64'(ack_timeout), 64'd0);
    step(1);
    check("to_at_16", 64'(ack_timeout), 64'(TO_EN));
    step(4);
    check("to_sticky", 64'(ack_timeout), 64'(TO_EN));

    // four-beat instance
    b_din = 128'h0123456789ABCDEF_FEDCBA9876543210; b_valid = 1'b1;
    step(1);
    b_valid = 1'b0;
    check("b4_level_1", 64'(b_level), 64'd1);
    step(1);
    check("b4_beat0_req", 64'(b_request), 64'd1);
    check("b4_beat0", 64'(b_dout), 64'h01234567);
    b_ack = 1'b1;
    step(2);
    check("b4_beat0_hold", 64'(b_dout), 64'h01234567);
    step(1);
    check("b4_beat1_req", 64'(b_request), 64'd0);
    check("b4_beat1", 64'(b_dout), 64'h89ABCDEF);
    b_ack = 1'b0;
    step(3);
    check("b4_beat2_req", 64'(b_request), 64'd1);
    check("b4_beat2", 64'(b_dout), 64'hFEDCBA98);
    b_ack = 1'b1;
    step(3);
    check("b4_beat3_req", 64'(b_request), 64'd0);
    check("b4_beat3", 64'(b_dout), 64'h76543210);
    b_ack = 1'b0;
    step(3);
    check("b4_done_level", 64'(b_level), 64'd0);
    check("b4_done_req_hold", 64'(b_request), 64'd0);
    check("b4_done_dout_hold", 64'(b_dout), 64'h76543210);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/req_ack_multibeat_sender.md
REQ_ACK_MULTIBEAT_SENDER -- requirements
Module: req_ack_multibeat_sender

Interface
REQ-001 Parameter DOUT_W, default 32: width of one transmitted beat.
REQ-002 Parameter BEATS, default 2: beats per input word, >=1; input width DIN_W = DOUT_W*BEATS.
REQ-003 Parameter FIFO_DEPTH, default 4: input words buffered, power of 2, >=2.
REQ-004 Parameter TIMEOUT_CYC, default 1024: ack watchdog limit in cycles, >=2; used only with the macro in REQ-030.
REQ-005 Port clk  in  1  single clock; all logic on the rising edge.
REQ-006 Port rstn  in  1  asynchronous, active-low reset.
REQ-007 Port din  in  DIN_W  word from the local chip.
REQ-008 Port valid  in  1  din is valid.
REQ-009 Port available  out  1  registered; high when the FIFO can accept a word.
REQ-010 Port level  out  clog2(FIFO_DEPTH+1)  registered count of buffered words.
REQ-011 Port request  out  1  2-phase request to the remote chip; every toggle marks one new beat.
REQ-012 Port acknowledge  in  1  asynchronous 2-phase ack from the remote chip.
REQ-013 Port dout  out  DOUT_W  registered beat data to the remote chip.
REQ-014 Port ack_timeout  out  1  sticky watchdog flag; see REQ-030.

Function
REQ-015 A word shall be written to the FIFO on an edge where valid & available; available shall be 1 on the next cycle only if level < FIFO_DEPTH.
REQ-016 acknowledge shall pass through two synchroniser flops and then one delay flop; ack_pulse = sync2 XOR delayed, so one ack toggle gives exactly one pulse on the 3rd edge.
REQ-017 The transmit FSM shall have two states: IDLE and WAIT_ACK.
REQ-018 In IDLE with level>0, on the next edge: dout <= head beat 0, request toggles, beat_cnt <= 0, state <= WAIT_ACK.
REQ-019 Beat order shall be MSB first: beat i = din[DIN_W-1-i*DOUT_W -: DOUT_W].
REQ-020 In WAIT_ACK with ack_pulse and beat_cnt < BEATS-1: beat_cnt++, dout <= next beat, request toggles, state unchanged.
REQ-021 In WAIT_ACK with ack_pulse and beat_cnt = BEATS-1: pop the head word, beat_cnt <= 0, state <= IDLE; request and dout hold.
REQ-022 An ack_pulse in IDLE shall be ignored; request, dout and level unchanged.
REQ-023 A push and a pop on the same edge shall leave level unchanged.
REQ-024 The FIFO pointers shall wrap modulo FIFO_DEPTH.
REQ-025 dout shall change only on a request toggle, so it is stable for the whole request phase.
REQ-026 With BEATS=1 every word is one beat; REQ-020 shall never fire.

Reset
REQ-027 When rstn is low: request=0, dout=0, available=1, level=0, ack_timeout=0, all ack flops 0, state IDLE, beat_cnt=0, FIFO pointers 0.
REQ-028 Reset in mid-transfer shall discard all buffered and in-flight words with no partial resume; the remote side is reset together with this block at system level.
REQ-029 Release of reset shall not create an ack_pulse while acknowledge is held low.

Configuration
REQ-030 Macro REQ_ACK_TIMEOUT_EN defined: a counter clears on every request toggle and counts cycles in WAIT_ACK; on reaching TIMEOUT_CYC, ack_timeout <= 1 and stays 1 until reset; there is no retransmission and the FSM keeps waiting.
REQ-031 Macro REQ_ACK_TIMEOUT_EN undefined: no counter is built and ack_timeout is tied to 0; the port list is identical in both builds.

Verification (DOUT_W=32, BEATS=2, FIFO_DEPTH=4 unless stated)
REQ-032 One word 0xAAAABBBB_CCCCDDDD, then ack toggled twice, each toggle made after the previous request toggle -> request 0->1 with dout=AAAABBBB; request 1->0 with dout=CCCCDDDD on the 3rd edge after ack toggle 1; IDLE and level=0 on the 3rd edge after ack toggle 2.
REQ-033 Five back-to-back valid words with ack held -> level=4 and available=0 after the 4th accept; 5th word not accepted; one full word completes -> level=3 and available=1 the next cycle.
REQ-034 Ack toggled while IDLE with an empty FIFO -> no request toggle and dout unchanged.
REQ-035 rstn pulsed low after beat 0 of a word with 3 words buffered -> request=0, dout=0, level=0 and available=1 immediately; no further request toggles.
REQ-036 BEATS=4, word 0x0123456789ABCDEF_FEDCBA9876543210 -> dout sequence 01234567, 89ABCDEF, FEDCBA98, 76543210 with four request toggles.
REQ-037 REQ_ACK_TIMEOUT_EN defined, TIMEOUT_CYC=16, ack never toggled -> ack_timeout rises 16 cycles after the request toggle and stays 1; without the macro ack_timeout stays 0.
